// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : UART-receiver handshake plus host-side FIFO port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          r_ready;
    logic [DW-1:0] r_dout;
    logic          r_perr;
    logic          r_ferr;
    logic          r_rdn;
    logic          h_rdn;
    logic [DW-1:0] h_q;
    logic          h_perr;
    logic          h_ferr;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          clr_ovr;

    modport slave (
        input  r_ready, r_dout, r_perr, r_ferr, h_rdn, clr_ovr,
        output r_rdn, h_q, h_perr, h_ferr, empty, full, count, overrun
    );

    modport master (
        output r_ready, r_dout, r_perr, r_ferr, h_rdn, clr_ovr,
        input  r_rdn, h_q, h_perr, h_ferr, empty, full, count, overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Acknowledges UART receive bytes and buffers them with error flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  wire logic       clk16x,
    input  wire logic       clrn,
    uart_rx_fifo_if.slave   bus
);
    localparam int          c_DEPTH_I = 1 << AW;
    localparam logic [AW:0] c_DEPTH   = (AW+1)'(c_DEPTH_I);
    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_ACK     = 2'd1;
    localparam logic [1:0]  c_WAIT    = 2'd2;

    logic [1:0]    r_state;
    logic          r_rdn;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovr;
    logic [DW+1:0] r_mem [c_DEPTH_I];

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_write;
    logic          w_drop;
    logic [DW+1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_push  = (r_state == c_IDLE) && bus.r_ready;
    assign w_pop   = !bus.h_rdn && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still stored.
    assign w_write = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_IDLE;
            r_rdn   <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.r_ready) begin
                        r_rdn   <= 1'b0;
                        r_state <= c_ACK;
                    end
                end
                c_ACK: begin
                    r_rdn   <= 1'b1;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (!bus.r_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_rdn   <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Storage needs no reset; unread entries are masked by the empty flag.
    always_ff @(posedge clk16x) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {bus.r_ferr, bus.r_perr, bus.r_dout};
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign bus.h_q     = w_empty ? '0 : w_head[DW-1:0];
    assign bus.h_perr  = w_empty ? 1'b0 : w_head[DW];
    assign bus.h_ferr  = w_empty ? 1'b0 : w_head[DW+1];
    assign bus.r_rdn   = r_rdn;
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.count   = r_count;
    assign bus.overrun = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Randomized self-checking bench for uart_rx_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int c_AW    = 4;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 1 << c_AW;

    logic clk;
    logic clrn;

    uart_rx_fifo_if #(.AW(c_AW), .DW(c_DW)) bus ();

    uart_rx_fifo #(.AW(c_AW), .DW(c_DW)) dut (
        .clk16x (clk),
        .clrn   (clrn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: entries are {ferr, perr, data}, oldest at the front.
    logic [9:0] m_q [$];
    bit         m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit push, input logic [9:0] d, input bit pop, input bit clr);
        bit do_pop;
        bit set;
        do_pop = pop && (m_q.size() > 0);
        set    = push && (m_q.size() == c_DEPTH) && !do_pop;
        if (do_pop) void'(m_q.pop_front());
        if (push && !set) m_q.push_back(d);
        if (set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic check_state();
        logic [9:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 10'd0;
        chk("count",   32'(bus.count),   32'(m_q.size()));
        chk("empty",   32'(bus.empty),   32'(m_q.size() == 0));
        chk("full",    32'(bus.full),    32'(m_q.size() == c_DEPTH));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("h_q",     32'(bus.h_q),     32'(h[7:0]));
        chk("h_perr",  32'(bus.h_perr),  32'(h[8]));
        chk("h_ferr",  32'(bus.h_ferr),  32'(h[9]));
    endtask

    // Mimics the UART: present a byte, expect one low r_rdn cycle, keep r_ready up a while.
    task automatic send(input logic [7:0] d, input bit pe, input bit fe,
                        input bit pop, input bit clr, input int hold);
        @(negedge clk);
        bus.r_ready = 1'b1; bus.r_dout = d; bus.r_perr = pe; bus.r_ferr = fe;
        bus.h_rdn = !pop; bus.clr_ovr = clr;
        @(posedge clk);
        model_step(1'b1, {fe, pe, d}, pop, clr);
        #1;
        chk("rdn_low", 32'(bus.r_rdn), 32'd0);
        check_state();
        @(negedge clk);
        bus.h_rdn = 1'b1; bus.clr_ovr = 1'b0;
        @(posedge clk);
        #1;
        chk("rdn_one_cycle", 32'(bus.r_rdn), 32'd1);
        repeat (hold) @(posedge clk);
        #1;
        chk("no_repush", 32'(bus.count), 32'(m_q.size()));
        @(negedge clk);
        bus.r_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rdn_idle", 32'(bus.r_rdn), 32'd1);
    endtask

    task automatic pop_one(input bit clr);
        @(negedge clk);
        bus.h_rdn = 1'b0; bus.clr_ovr = clr;
        @(posedge clk);
        model_step(1'b0, 10'd0, 1'b1, clr);
        #1;
        check_state();
        @(negedge clk);
        bus.h_rdn = 1'b1; bus.clr_ovr = 1'b0;
    endtask

    task automatic clr_only();
        @(negedge clk);
        bus.clr_ovr = 1'b1;
        @(posedge clk);
        model_step(1'b0, 10'd0, 1'b0, 1'b1);
        #1;
        check_state();
        @(negedge clk);
        bus.clr_ovr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.r_ready = 1'b0; bus.r_dout = '0; bus.r_perr = 1'b0; bus.r_ferr = 1'b0;
        bus.h_rdn = 1'b1; bus.clr_ovr = 1'b0;
        m_ovr = 1'b0;

        // Reset values
        clrn = 1'b0;
        #10;
        chk("rst_rdn", 32'(bus.r_rdn), 32'd1);
        chk("rst_h_q", 32'(bus.h_q), 32'd0);
        check_state();
        @(negedge clk);
        clrn = 1'b1;

        // Two bytes, then drain
        send(8'he1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("t2_head", 32'(bus.h_q), 32'he1);
        chk("t2_count", 32'(bus.count), 32'd2);
        pop_one(1'b0);
        chk("t2_head2", 32'(bus.h_q), 32'h55);
        pop_one(1'b0);
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // r_ready held for 5 cycles gives a single push
        send(8'ha5, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        chk("t3_count", 32'(bus.count), 32'd1);
        pop_one(1'b0);

        // Overflow by one: 0x10 is dropped
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("t4_full", 32'(bus.full), 32'd1);
        chk("t4_ovr", 32'(bus.overrun), 32'd1);
        chk("t4_head", 32'(bus.h_q), 32'h00);
        for (int i = 0; i < 16; i++) pop_one(1'b0);
        chk("t4_empty", 32'(bus.empty), 32'd1);
        clr_only();
        chk("t4_clr", 32'(bus.overrun), 32'd0);

        // Full FIFO with simultaneous push and pop, wrapping the pointers
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 40; i++) send(8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("t5_count", 32'(bus.count), 32'd16);
        chk("t5_ovr", 32'(bus.overrun), 32'd0);
        // Set beats a simultaneous clear
        send(8'hee, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        chk("t5_set_wins", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 16; i++) pop_one(1'b0);

        // Error flags travel with their byte
        send(8'h3c, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("t6_q", 32'(bus.h_q), 32'h3c);
        chk("t6_perr", 32'(bus.h_perr), 32'd1);
        chk("t6_ferr", 32'(bus.h_ferr), 32'd1);
        send(8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pop_one(1'b0);
        chk("t6_next_perr", 32'(bus.h_perr), 32'd0);
        clr_only();
        chk("t6_clr", 32'(bus.overrun), 32'd0);

        // Reset in the middle of a handshake; the still-ready byte is taken as new
        @(negedge clk);
        bus.r_ready = 1'b1; bus.r_dout = 8'h77; bus.r_perr = 1'b0; bus.r_ferr = 1'b0;
        @(posedge clk);
        model_step(1'b1, 10'h077, 1'b0, 1'b0);
        #1;
        chk("mid_rdn_low", 32'(bus.r_rdn), 32'd0);
        #2;
        clrn = 1'b0;
        #1;
        m_q.delete();
        m_ovr = 1'b0;
        chk("mid_rst_rdn", 32'(bus.r_rdn), 32'd1);
        check_state();
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        model_step(1'b1, 10'h077, 1'b0, 1'b0);
        #1;
        chk("mid_reack", 32'(bus.r_rdn), 32'd0);
        check_state();
        @(negedge clk);
        bus.r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rdn_hi", 32'(bus.r_rdn), 32'd1);
        check_state();

        // Randomized mix, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 320; i++) begin
            int unsigned r;
            int unsigned push_pct;
            push_pct = ((i / 40) % 2 == 0) ? 80 : 30;
            r = $urandom_range(0, 99);
            if (r < push_pct) begin
                send(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, 3)));
            end else if (r < 95) begin
                pop_one($urandom_range(0, 7) == 0);
            end else begin
                clr_only();
            end
        end
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
